// File: rtl/shift_exec_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_exec_stage_if                                                        |
// | Decode-side request, writeback-side response and flush for the shift stage |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface shift_exec_stage_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_src;
    logic [31:0]           in_shreg;
    logic [4:0]            in_imm;
    logic                  in_var;
    logic                  in_type;
    logic                  in_dir;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_carry;
    logic                  out_zero;

    modport master (
        output flush, in_valid, in_src, in_shreg, in_imm, in_var, in_type, in_dir, in_rd,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_carry, out_zero
    );

    modport slave (
        input  flush, in_valid, in_src, in_shreg, in_imm, in_var, in_type, in_dir, in_rd,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd, out_carry, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_exec_stage                                                           |
// | Two-stage valid/ready execute wrapper around a 32-bit barrel shifter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_exec_stage #(
    parameter int REG_ADDR_W = 5
) (
    input  wire                 clk,
    input  wire                 rst,
    shift_exec_stage_if.slave   bus_io
);
    logic                  s1_valid_q, s1_valid_d;
    logic [31:0]           s1_src_q,   s1_src_d;
    logic [4:0]            s1_shamt_q, s1_shamt_d;
    logic                  s1_type_q,  s1_type_d;
    logic                  s1_dir_q,   s1_dir_d;
    logic [REG_ADDR_W-1:0] s1_rd_q,    s1_rd_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [31:0]           s2_result_q, s2_result_d;
    logic [REG_ADDR_W-1:0] s2_rd_q,    s2_rd_d;
    logic                  s2_carry_q, s2_carry_d;
    logic                  s2_zero_q,  s2_zero_d;

    logic        w_s2_adv;
    logic        w_s1_load;
    logic        w_accept;
    logic [32:0] w_left;
    logic [32:0] w_right;
    logic [31:0] w_sh_result;
    logic        w_sh_carry;

    assign w_s2_adv  = !s2_valid_q || bus_io.out_ready;
    assign w_s1_load = !s1_valid_q || w_s2_adv;
    assign w_accept  = bus_io.in_valid && w_s1_load && !bus_io.flush;

    assign bus_io.in_ready   = w_s1_load && !bus_io.flush;
    assign bus_io.out_valid  = s2_valid_q;
    assign bus_io.out_result = s2_result_q;
    assign bus_io.out_rd     = s2_rd_q;
    assign bus_io.out_carry  = s2_carry_q;
    assign bus_io.out_zero   = s2_zero_q;

    // A 33rd bit on the far side of the shift catches the last bit shifted out;
    // with shamt=0 that bit stays 0, giving carry=0 for free.
    always_comb begin
        w_left      = {1'b0, s1_src_q} << s1_shamt_q;
        w_right     = s1_type_q ? 33'($signed({s1_src_q, 1'b0}) >>> s1_shamt_q)
                                : ({s1_src_q, 1'b0} >> s1_shamt_q);
        w_sh_result = s1_dir_q ? w_right[32:1] : w_left[31:0];
        w_sh_carry  = s1_dir_q ? w_right[0]    : w_left[32];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_src_d    = s1_src_q;
        s1_shamt_d  = s1_shamt_q;
        s1_type_d   = s1_type_q;
        s1_dir_d    = s1_dir_q;
        s1_rd_d     = s1_rd_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_rd_d     = s2_rd_q;
        s2_carry_d  = s2_carry_q;
        s2_zero_d   = s2_zero_q;

        if (bus_io.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (w_s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d = w_sh_result;
                    s2_rd_d     = s1_rd_q;
                    s2_carry_d  = w_sh_carry;
                    s2_zero_d   = (w_sh_result == 32'd0);
                end
            end
            if (w_s1_load) begin
                s1_valid_d = bus_io.in_valid;
                if (w_accept) begin
                    s1_src_d   = bus_io.in_src;
                    s1_shamt_d = bus_io.in_var ? bus_io.in_shreg[4:0] : bus_io.in_imm;
                    s1_type_d  = bus_io.in_type;
                    s1_dir_d   = bus_io.in_dir;
                    s1_rd_d    = bus_io.in_rd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_src_q    <= 32'd0;
            s1_shamt_q  <= 5'd0;
            s1_type_q   <= 1'b0;
            s1_dir_q    <= 1'b0;
            s1_rd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'd0;
            s2_rd_q     <= '0;
            s2_carry_q  <= 1'b0;
            s2_zero_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_src_q    <= s1_src_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_type_q   <= s1_type_d;
            s1_dir_q    <= s1_dir_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_rd_q     <= s2_rd_d;
            s2_carry_q  <= s2_carry_d;
            s2_zero_q   <= s2_zero_d;
        end
    end
endmodule
`default_nettype wire
